// File: rtl/img_proc_pkg.sv
// Shared frame constants, pixel helpers and Gaussian weights used by the
// image processing passes.
package img_proc_pkg;

    localparam int FRAME_W       = 320;
    localparam int FRAME_H       = 240;
    localparam int FRAME_AW      = 17;
    localparam int FB_RD_LATENCY = 2;

    typedef logic [3:0]  gray_t;
    typedef logic [11:0] rgb444_t;

    // 3x3 kernel is the outer product of [1 2 1], so corners/edges/centre take 1/2/4
    localparam logic [7:0] K_CORNER = 8'd1;
    localparam logic [7:0] K_EDGE   = 8'd2;
    localparam logic [7:0] K_CENTER = 8'd4;

    function automatic gray_t gray_of(input rgb444_t pix);
        return pix[3:0];
    endfunction

    function automatic rgb444_t gray_to_rgb(input gray_t g);
        return {g, g, g};
    endfunction

endpackage

// File: rtl/gauss_line_buffer.sv
// Two cascaded row delays of DEPTH samples each, giving the two rows above
// the sample currently entering the blur window.
module gauss_line_buffer
    import img_proc_pkg::*;
#(
    parameter int DEPTH = FRAME_W + 1
) (
    input  logic  clk_25_vga,
    input  logic  reset_global,
    input  logic  rst_i,
    input  logic  shift_en,
    input  gray_t sample,
    output gray_t row_above,
    output gray_t row_two_above
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    gray_t         line1 [DEPTH];
    gray_t         line2 [DEPTH];
    logic [PW-1:0] ptr;

    assign row_above     = line1[ptr];
    assign row_two_above = line2[ptr];

    // Storage carries no reset so it can map onto distributed RAM; stale
    // contents only ever reach border pixels, which ignore them.
    always_ff @(posedge clk_25_vga) begin
        if (shift_en) begin
            line1[ptr] <= sample;
            line2[ptr] <= line1[ptr];
        end
    end

    always_ff @(posedge clk_25_vga or posedge reset_global) begin
        if (reset_global) begin
            ptr <= '0;
        end else if (rst_i) begin
            ptr <= '0;
        end else if (shift_en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/gauss_blur_pass.sv
// Single-shot 3x3 Gaussian smoothing pass: scans frame buffer 1 in raster
// order and writes the blurred frame, copying border pixels unchanged.
module gauss_blur_pass
    import img_proc_pkg::*;
#(
    parameter int W          = FRAME_W,
    parameter int H          = FRAME_H,
    parameter int AW         = FRAME_AW,
    parameter int RD_LATENCY = FB_RD_LATENCY
) (
    input  logic          clk_25_vga,
    input  logic          reset_global,
    input  logic          rst_i,
    input  logic          enable,
    output logic          done,
    output logic [AW-1:0] rdaddr,
    input  logic [11:0]   din,
    output logic [AW-1:0] wraddr,
    output logic [11:0]   dout,
    output logic          we
);

    localparam int XW   = $clog2(W + 1);
    localparam int YW   = $clog2(H + 1);
    localparam int NPIX = W * H;
    localparam int CW   = $clog2(NPIX + 1);
    localparam logic [XW-1:0] X_LAST = XW'(W);
    localparam logic [YW-1:0] Y_LAST = YW'(H);

    logic [XW-1:0] step_x;
    logic [YW-1:0] step_y;
    logic          scan_end;
    logic          step_fire;
    logic          step_dummy;

    logic [RD_LATENCY:0]         pv;
    logic [RD_LATENCY:0]         pd;
    logic [RD_LATENCY:0][XW-1:0] px;
    logic [RD_LATENCY:0][YW-1:0] py;

    gray_t aligned_sample;
    gray_t row_above;
    gray_t row_two_above;

    gray_t p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic          win_valid;
    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;

    logic [7:0]    blur_sum;
    gray_t         blur_gray;
    logic          is_border;
    logic          produce;
    logic [CW-1:0] wr_count;

    assign step_fire  = enable && !done && !scan_end && !rst_i;
    assign step_dummy = (step_x == X_LAST) || (step_y == Y_LAST);

    // Scan counters include one extra column and row of dummy steps so the
    // last real row and column still get a full window behind them.
    always_ff @(posedge clk_25_vga or posedge reset_global) begin
        if (reset_global) begin
            step_x   <= '0;
            step_y   <= '0;
            scan_end <= 1'b0;
            rdaddr   <= '0;
        end else if (rst_i) begin
            step_x   <= '0;
            step_y   <= '0;
            scan_end <= 1'b0;
            rdaddr   <= '0;
        end else if (step_fire) begin
            if (!step_dummy) begin
                rdaddr <= AW'(int'(step_y) * W + int'(step_x));
            end
            if (step_x == X_LAST) begin
                step_x <= '0;
                if (step_y == Y_LAST) begin
                    scan_end <= 1'b1;
                end else begin
                    step_y <= step_y + YW'(1);
                end
            end else begin
                step_x <= step_x + XW'(1);
            end
        end
    end

    // Step tags travel alongside the frame buffer read so they line up with din.
    always_ff @(posedge clk_25_vga or posedge reset_global) begin
        if (reset_global) begin
            pv <= '0;
            pd <= '0;
            px <= '0;
            py <= '0;
        end else if (rst_i) begin
            pv <= '0;
            pd <= '0;
            px <= '0;
            py <= '0;
        end else begin
            pv <= {pv[RD_LATENCY-1:0], step_fire};
            pd <= {pd[RD_LATENCY-1:0], step_dummy};
            px <= {px[RD_LATENCY-1:0], step_x};
            py <= {py[RD_LATENCY-1:0], step_y};
        end
    end

    assign aligned_sample = pd[RD_LATENCY] ? 4'd0 : gray_of(din);

    gauss_line_buffer #(
        .DEPTH (W + 1)
    ) u_line_buffer (
        .clk_25_vga    (clk_25_vga),
        .reset_global  (reset_global),
        .rst_i         (rst_i),
        .shift_en      (pv[RD_LATENCY]),
        .sample        (aligned_sample),
        .row_above     (row_above),
        .row_two_above (row_two_above)
    );

    always_ff @(posedge clk_25_vga or posedge reset_global) begin
        if (reset_global) begin
            {p00, p01, p02, p10, p11, p12, p20, p21, p22} <= '0;
            win_valid <= 1'b0;
            win_x     <= '0;
            win_y     <= '0;
        end else if (rst_i) begin
            {p00, p01, p02, p10, p11, p12, p20, p21, p22} <= '0;
            win_valid <= 1'b0;
            win_x     <= '0;
            win_y     <= '0;
        end else begin
            win_valid <= pv[RD_LATENCY];
            if (pv[RD_LATENCY]) begin
                p00   <= p01;
                p01   <= p02;
                p02   <= row_two_above;
                p10   <= p11;
                p11   <= p12;
                p12   <= row_above;
                p20   <= p21;
                p21   <= p22;
                p22   <= aligned_sample;
                win_x <= px[RD_LATENCY];
                win_y <= py[RD_LATENCY];
            end
        end
    end

    // The window centre is pixel (win_x-1, win_y-1); borders bypass the kernel.
    always_comb begin
        blur_sum = K_CORNER * (8'(p00) + 8'(p02) + 8'(p20) + 8'(p22))
                 + K_EDGE   * (8'(p01) + 8'(p10) + 8'(p12) + 8'(p21))
                 + K_CENTER * 8'(p11);
    end

    assign is_border = (win_x == XW'(1)) || (win_x == X_LAST) ||
                       (win_y == YW'(1)) || (win_y == Y_LAST);
    assign produce   = win_valid && (win_x != '0) && (win_y != '0);
    assign blur_gray = is_border ? p11 : blur_sum[7:4];

    always_ff @(posedge clk_25_vga or posedge reset_global) begin
        if (reset_global) begin
            we       <= 1'b0;
            wraddr   <= '0;
            dout     <= '0;
            done     <= 1'b0;
            wr_count <= '0;
        end else if (rst_i) begin
            we       <= 1'b0;
            wraddr   <= '0;
            dout     <= '0;
            done     <= 1'b0;
            wr_count <= '0;
        end else begin
            we <= produce;
            if (produce) begin
                wraddr <= AW'((int'(win_y) - 1) * W + int'(win_x) - 1);
                dout   <= gray_to_rgb(blur_gray);
            end
            if (we) begin
                wr_count <= wr_count + CW'(1);
                if (wr_count == CW'(NPIX - 1)) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
